// File: rtl/grid_video_gen_if.sv
// rtl/grid_video_gen_if.sv - pixel and sync bundle from grid_video_gen to the TMDS encoders
interface grid_video_gen_if;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
    logic       hsync;
    logic       vsync;
    logic       de;
    logic       frame_start;

    modport master (output red, green, blue, hsync, vsync, de, frame_start);
    modport slave  (input  red, green, blue, hsync, vsync, de, frame_start);
endinterface

// File: rtl/grid_video_gen.sv
// rtl/grid_video_gen.sv - raster timing generator drawing a COLS x ROWS colour cell grid
module grid_video_gen #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter bit SYNC_POL     = 1'b1,
    parameter int COLS         = 3,
    parameter int ROWS         = 3,
    parameter int BORDER       = 2,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                   pixclk,
    input  logic                   rst_n,
    input  logic [3*COLS*ROWS-1:0] cell_rgb,
    input  logic                   cursor_en,
    input  logic [7:0]             cursor_idx,
    grid_video_gen_if.master       vid
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int XW      = $clog2(H_TOTAL + 1);
    localparam int YW      = $clog2(V_TOTAL + 1);
    localparam int CW      = H_ACTIVE / COLS;
    localparam int CH      = V_ACTIVE / ROWS;
    localparam int NBITS   = 3 * COLS * ROWS;
    localparam int FW      = $clog2(BLINK_FRAMES + 1);

    localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] X_ACT    = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS_BEG   = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [XW-1:0] CW_LAST  = XW'(CW - 1);
    localparam logic [XW-1:0] B_X      = XW'(BORDER);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] Y_ACT    = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VS_BEG   = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [YW-1:0] CH_LAST  = YW'(CH - 1);
    localparam logic [YW-1:0] B_Y      = YW'(BORDER);
    localparam logic [3:0]    COL_LAST = 4'(COLS - 1);
    localparam logic [3:0]    ROW_LAST = 4'(ROWS - 1);
    localparam logic [FW-1:0] FC_LAST  = FW'(BLINK_FRAMES - 1);

    if (COLS < 1 || COLS > 16 || ROWS < 1 || ROWS > 16 || BLINK_FRAMES < 1 ||
        BORDER < 0 || BORDER >= CW || BORDER >= CH) begin : g_bad_params
        $error("grid_video_gen: illegal parameter combination");
    end

    // raster position, cell position and offset inside the cell
    logic [XW-1:0]    x_q, x_d, xs_q, xs_d;
    logic [YW-1:0]    y_q, y_d, ys_q, ys_d;
    logic [3:0]       col_q, col_d, row_q, row_d;
    // per-frame snapshot of the inputs and the blink state
    logic [NBITS-1:0] snap_rgb_q, snap_rgb_d;
    logic             snap_cen_q, snap_cen_d;
    logic [7:0]       snap_cidx_q, snap_cidx_d;
    logic             snap_blink_q, snap_blink_d;
    logic [FW-1:0]    frame_cnt_q, frame_cnt_d;
    logic             blink_next_q, blink_next_d;
    // pipeline stage 1: decoded position
    logic             s1_de_q, s1_de_d, s1_hs_q, s1_hs_d;
    logic             s1_vs_q, s1_vs_d, s1_fs_q, s1_fs_d;
    logic [2:0]       s1_rgb_q, s1_rgb_d;
    // pipeline stage 2: registered outputs
    logic [7:0]       red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic             hsync_q, hsync_d, vsync_q, vsync_d;
    logic             de_q, de_d, frame_start_q, frame_start_d;

    logic             x_wrap, frame_end, active, border_hit, cursor_hit;
    logic [7:0]       cell_idx;
    logic [2:0]       cell_bits;

    assign x_wrap     = (x_q == X_LAST);
    assign frame_end  = x_wrap && (y_q == Y_LAST);
    assign active     = (x_q < X_ACT) && (y_q < Y_ACT);
    assign cell_idx   = 8'(row_q) * 8'(COLS) + 8'(col_q);
    assign cell_bits  = snap_rgb_q[3*cell_idx +: 3];
    assign border_hit = ((col_q != 4'd0) && (xs_q < B_X)) ||
                        ((row_q != 4'd0) && (ys_q < B_Y));
    assign cursor_hit = snap_cen_q && snap_blink_q && (cell_idx == snap_cidx_q);

    // next-state: counters, snapshot, blink bookkeeping and the two pipeline stages
    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        xs_d          = xs_q;
        ys_d          = ys_q;
        col_d         = col_q;
        row_d         = row_q;
        snap_rgb_d    = snap_rgb_q;
        snap_cen_d    = snap_cen_q;
        snap_cidx_d   = snap_cidx_q;
        snap_blink_d  = snap_blink_q;
        frame_cnt_d   = frame_cnt_q;
        blink_next_d  = blink_next_q;

        // horizontal: the last column keeps counting, absorbing the remainder
        if (x_wrap) begin
            x_d   = '0;
            xs_d  = '0;
            col_d = '0;
        end else begin
            x_d = x_q + 1'b1;
            if ((xs_q == CW_LAST) && (col_q != COL_LAST)) begin
                xs_d  = '0;
                col_d = col_q + 1'b1;
            end else begin
                xs_d = xs_q + 1'b1;
            end
        end

        // vertical advances once per line, on the horizontal wrap
        if (x_wrap) begin
            if (frame_end) begin
                y_d   = '0;
                ys_d  = '0;
                row_d = '0;
            end else begin
                y_d = y_q + 1'b1;
                if ((ys_q == CH_LAST) && (row_q != ROW_LAST)) begin
                    ys_d  = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    ys_d = ys_q + 1'b1;
                end
            end
        end

        // blink toggles are staged in blink_next and only picked up at frame end
        if (frame_start_q) begin
            if (frame_cnt_q == FC_LAST) begin
                frame_cnt_d  = '0;
                blink_next_d = ~blink_next_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end

        if (frame_end) begin
            snap_rgb_d   = cell_rgb;
            snap_cen_d   = cursor_en;
            snap_cidx_d  = cursor_idx;
            snap_blink_d = blink_next_q;
        end

        s1_de_d = active;
        s1_hs_d = (x_q >= HS_BEG) && (x_q < HS_END);
        s1_vs_d = (y_q >= VS_BEG) && (y_q < VS_END);
        s1_fs_d = (x_q == '0) && (y_q == '0);
        if (!active)         s1_rgb_d = 3'b000;
        else if (border_hit) s1_rgb_d = 3'b111;
        else if (cursor_hit) s1_rgb_d = ~cell_bits;
        else                 s1_rgb_d = cell_bits;

        red_d         = {8{s1_rgb_q[2]}};
        green_d       = {8{s1_rgb_q[1]}};
        blue_d        = {8{s1_rgb_q[0]}};
        hsync_d       = s1_hs_q ? SYNC_POL : ~SYNC_POL;
        vsync_d       = s1_vs_q ? SYNC_POL : ~SYNC_POL;
        de_d          = s1_de_q;
        frame_start_d = s1_fs_q;
    end

    // state registers, all cleared asynchronously
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            x_q           <= '0;
            y_q           <= '0;
            xs_q          <= '0;
            ys_q          <= '0;
            col_q         <= '0;
            row_q         <= '0;
            snap_rgb_q    <= '0;
            snap_cen_q    <= 1'b0;
            snap_cidx_q   <= '0;
            snap_blink_q  <= 1'b0;
            frame_cnt_q   <= '0;
            blink_next_q  <= 1'b0;
            s1_de_q       <= 1'b0;
            s1_hs_q       <= 1'b0;
            s1_vs_q       <= 1'b0;
            s1_fs_q       <= 1'b0;
            s1_rgb_q      <= '0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            de_q          <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            xs_q          <= xs_d;
            ys_q          <= ys_d;
            col_q         <= col_d;
            row_q         <= row_d;
            snap_rgb_q    <= snap_rgb_d;
            snap_cen_q    <= snap_cen_d;
            snap_cidx_q   <= snap_cidx_d;
            snap_blink_q  <= snap_blink_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_next_q  <= blink_next_d;
            s1_de_q       <= s1_de_d;
            s1_hs_q       <= s1_hs_d;
            s1_vs_q       <= s1_vs_d;
            s1_fs_q       <= s1_fs_d;
            s1_rgb_q      <= s1_rgb_d;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vid.red         = red_q;
    assign vid.green       = green_q;
    assign vid.blue        = blue_q;
    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
    assign vid.de          = de_q;
    assign vid.frame_start = frame_start_q;
endmodule

// File: tb/tb_grid_video_gen.sv
// tb/tb_grid_video_gen.sv - randomized reference-model bench for grid_video_gen
`timescale 1ns/1ps
module tb_grid_video_gen;
    typedef struct {
        int ha, hfp, hs, hbp, va, vfp, vs, vbp, pol, cols, rows, border, blink;
    } cfg_t;

    localparam int FA = 800 * 525;
    localparam int FB = 27 * 14;
    localparam int FC = 28 * 11;
    localparam logic [27:0] RST_POS = 28'h0000000;
    localparam logic [27:0] RST_NEG = 28'h000000C;

    cfg_t cfg_a, cfg_b, cfg_c;

    logic        pixclk = 1'b0;
    logic        rst_n  = 1'b0;
    logic [26:0] rgb_a, rgb_b;
    logic [23:0] rgb_c;
    logic        cen_a, cen_b, cen_c;
    logic [7:0]  idx_a, idx_b, idx_c;

    int checks = 0;
    int errors = 0;

    grid_video_gen_if vid_a();
    grid_video_gen_if vid_b();
    grid_video_gen_if vid_c();

    grid_video_gen u_a (
        .pixclk(pixclk), .rst_n(rst_n), .cell_rgb(rgb_a),
        .cursor_en(cen_a), .cursor_idx(idx_a), .vid(vid_a)
    );

    grid_video_gen #(
        .H_ACTIVE(20), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b0), .COLS(3), .ROWS(3), .BORDER(1), .BLINK_FRAMES(2)
    ) u_b (
        .pixclk(pixclk), .rst_n(rst_n), .cell_rgb(rgb_b),
        .cursor_en(cen_b), .cursor_idx(idx_b), .vid(vid_b)
    );

    grid_video_gen #(
        .H_ACTIVE(24), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b1), .COLS(4), .ROWS(2), .BORDER(0), .BLINK_FRAMES(1)
    ) u_c (
        .pixclk(pixclk), .rst_n(rst_n), .cell_rgb(rgb_c),
        .cursor_en(cen_c), .cursor_idx(idx_c), .vid(vid_c)
    );

    always #5 pixclk = ~pixclk;

    // kc counts rising edges since reset release; the inputs present on the
    // edge that closes frame m-1 become the snapshot used for frame m
    int          kc = 0;
    logic [47:0] srgb_a [64];
    logic [47:0] srgb_b [64];
    logic [47:0] srgb_c [64];
    logic        scen_a [64];
    logic        scen_b [64];
    logic        scen_c [64];
    logic [7:0]  sidx_a [64];
    logic [7:0]  sidx_b [64];
    logic [7:0]  sidx_c [64];

    always @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            kc        <= 0;
            srgb_a[0] <= '0; scen_a[0] <= 1'b0; sidx_a[0] <= '0;
            srgb_b[0] <= '0; scen_b[0] <= 1'b0; sidx_b[0] <= '0;
            srgb_c[0] <= '0; scen_c[0] <= 1'b0; sidx_c[0] <= '0;
        end else begin
            kc <= kc + 1;
            if ((kc + 1) % FA == 0) begin
                srgb_a[((kc + 1) / FA) % 64] <= 48'(rgb_a);
                scen_a[((kc + 1) / FA) % 64] <= cen_a;
                sidx_a[((kc + 1) / FA) % 64] <= idx_a;
            end
            if ((kc + 1) % FB == 0) begin
                srgb_b[((kc + 1) / FB) % 64] <= 48'(rgb_b);
                scen_b[((kc + 1) / FB) % 64] <= cen_b;
                sidx_b[((kc + 1) / FB) % 64] <= idx_b;
            end
            if ((kc + 1) % FC == 0) begin
                srgb_c[((kc + 1) / FC) % 64] <= 48'(rgb_c);
                scen_c[((kc + 1) / FC) % 64] <= cen_c;
                sidx_c[((kc + 1) / FC) % 64] <= idx_c;
            end
        end
    end

    // expected {red, green, blue, hsync, vsync, de, frame_start} for linear
    // raster position p counted from (0,0) after reset; p < 0 means still in reset
    function automatic logic [27:0] model(cfg_t c, int p, logic [47:0] srgb,
                                          logic scen, logic [7:0] sidx);
        int ht, vt, fr, q, x, y, cw, ch, col, row, xo, yo, n;
        logic pol, hs, vs, de, fs;
        logic [2:0] bits;
        pol = (c.pol != 0);
        if (p < 0) return {24'd0, ~pol, ~pol, 1'b0, 1'b0};
        ht = c.ha + c.hfp + c.hs + c.hbp;
        vt = c.va + c.vfp + c.vs + c.vbp;
        fr = p / (ht * vt);
        q  = p % (ht * vt);
        x  = q % ht;
        y  = q / ht;
        hs = (x >= c.ha + c.hfp && x < c.ha + c.hfp + c.hs) ? pol : ~pol;
        vs = (y >= c.va + c.vfp && y < c.va + c.vfp + c.vs) ? pol : ~pol;
        de = (x < c.ha) && (y < c.va);
        fs = (x == 0) && (y == 0);
        bits = 3'b000;
        if (de) begin
            cw  = c.ha / c.cols;
            ch  = c.va / c.rows;
            col = (x / cw > c.cols - 1) ? c.cols - 1 : x / cw;
            row = (y / ch > c.rows - 1) ? c.rows - 1 : y / ch;
            xo  = x - col * cw;
            yo  = y - row * ch;
            n   = row * c.cols + col;
            bits = srgb[3*n +: 3];
            if ((col > 0 && xo < c.border) || (row > 0 && yo < c.border))
                bits = 3'b111;
            else if (scen && (int'(sidx) == n) && ((fr / c.blink) % 2 == 1))
                bits = ~bits;
        end
        return {{8{bits[2]}}, {8{bits[1]}}, {8{bits[0]}}, hs, vs, de, fs};
    endfunction

    function automatic int frame_slot(int p, int f);
        return (p < 0) ? 0 : (p / f) % 64;
    endfunction

    task automatic test_reset();
        logic [27:0] got;
        for (int i = 0; i < 3; i++) begin
            @(negedge pixclk);
            got = {vid_a.red, vid_a.green, vid_a.blue, vid_a.hsync, vid_a.vsync, vid_a.de, vid_a.frame_start};
            checks++;
            if (got !== RST_POS) begin
                errors++;
                $display("FAIL reset_a got=%h exp=%h", got, RST_POS);
            end
            got = {vid_b.red, vid_b.green, vid_b.blue, vid_b.hsync, vid_b.vsync, vid_b.de, vid_b.frame_start};
            checks++;
            if (got !== RST_NEG) begin
                errors++;
                $display("FAIL reset_b got=%h exp=%h", got, RST_NEG);
            end
            got = {vid_c.red, vid_c.green, vid_c.blue, vid_c.hsync, vid_c.vsync, vid_c.de, vid_c.frame_start};
            checks++;
            if (got !== RST_POS) begin
                errors++;
                $display("FAIL reset_c got=%h exp=%h", got, RST_POS);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_default_timing();
        logic [27:0] got, exp;
        int p, s;
        for (int i = 0; i < 2 * 800 + 20; i++) begin
            @(negedge pixclk);
            p   = kc - 2;
            s   = frame_slot(p, FA);
            exp = model(cfg_a, p, srgb_a[s], scen_a[s], sidx_a[s]);
            got = {vid_a.red, vid_a.green, vid_a.blue, vid_a.hsync, vid_a.vsync, vid_a.de, vid_a.frame_start};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL default_timing k=%0d got=%h exp=%h", kc, got, exp);
            end
        end
    endtask

    task automatic test_cells_random();
        logic [27:0] got, exp;
        int p, s;
        for (int i = 0; i < 6 * FC; i++) begin
            @(negedge pixclk);
            p   = kc - 2;
            s   = frame_slot(p, FC);
            exp = model(cfg_c, p, srgb_c[s], scen_c[s], sidx_c[s]);
            got = {vid_c.red, vid_c.green, vid_c.blue, vid_c.hsync, vid_c.vsync, vid_c.de, vid_c.frame_start};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL cells_random k=%0d got=%h exp=%h", kc, got, exp);
            end
            if ($urandom_range(0, 39) == 0) begin
                rgb_c = 24'($urandom);
                cen_c = 1'($urandom);
                idx_c = 8'($urandom_range(0, 9));
            end
        end
    endtask

    task automatic test_border_cursor();
        logic [27:0] got, exp;
        int p, s, pick;
        for (int i = 0; i < 10 * FB; i++) begin
            @(negedge pixclk);
            p   = kc - 2;
            s   = frame_slot(p, FB);
            exp = model(cfg_b, p, srgb_b[s], scen_b[s], sidx_b[s]);
            got = {vid_b.red, vid_b.green, vid_b.blue, vid_b.hsync, vid_b.vsync, vid_b.de, vid_b.frame_start};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL border_cursor k=%0d got=%h exp=%h", kc, got, exp);
            end
            if ($urandom_range(0, 59) == 0) begin
                rgb_b = 27'($urandom);
                if ($urandom_range(0, 1) == 0) rgb_b[26:24] = 3'b000;
                cen_b = ($urandom_range(0, 3) != 0);
                pick  = $urandom_range(0, 3);
                idx_b = (pick == 0) ? 8'd8 : (pick == 1) ? 8'd9 :
                        (pick == 2) ? 8'($urandom_range(0, 8)) : 8'($urandom);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [27:0] got, exp;
        int p, s;
        for (int i = 0; i < FB && ((kc - 2) % FB) != 150; i++) @(negedge pixclk);
        #2 rst_n = 1'b0;
        #1;
        got = {vid_a.red, vid_a.green, vid_a.blue, vid_a.hsync, vid_a.vsync, vid_a.de, vid_a.frame_start};
        checks++;
        if (got !== RST_POS) begin
            errors++;
            $display("FAIL async_reset_a got=%h exp=%h", got, RST_POS);
        end
        got = {vid_b.red, vid_b.green, vid_b.blue, vid_b.hsync, vid_b.vsync, vid_b.de, vid_b.frame_start};
        checks++;
        if (got !== RST_NEG) begin
            errors++;
            $display("FAIL async_reset_b got=%h exp=%h", got, RST_NEG);
        end
        got = {vid_c.red, vid_c.green, vid_c.blue, vid_c.hsync, vid_c.vsync, vid_c.de, vid_c.frame_start};
        checks++;
        if (got !== RST_POS) begin
            errors++;
            $display("FAIL async_reset_c got=%h exp=%h", got, RST_POS);
        end
        repeat (3) @(negedge pixclk);
        rst_n = 1'b1;
        for (int i = 0; i < 2 * FB + 10; i++) begin
            @(negedge pixclk);
            p   = kc - 2;
            s   = frame_slot(p, FB);
            exp = model(cfg_b, p, srgb_b[s], scen_b[s], sidx_b[s]);
            got = {vid_b.red, vid_b.green, vid_b.blue, vid_b.hsync, vid_b.vsync, vid_b.de, vid_b.frame_start};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL restart_b k=%0d got=%h exp=%h", kc, got, exp);
            end
            s   = frame_slot(p, FC);
            exp = model(cfg_c, p, srgb_c[s], scen_c[s], sidx_c[s]);
            got = {vid_c.red, vid_c.green, vid_c.blue, vid_c.hsync, vid_c.vsync, vid_c.de, vid_c.frame_start};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL restart_c k=%0d got=%h exp=%h", kc, got, exp);
            end
        end
    endtask

    initial begin
        cfg_a = '{640, 16, 96, 48, 480, 10, 2, 33, 1, 3, 3, 2, 30};
        cfg_b = '{20, 2, 3, 2, 10, 1, 2, 1, 0, 3, 3, 1, 2};
        cfg_c = '{24, 1, 2, 1, 8, 1, 1, 1, 1, 4, 2, 0, 1};
        rgb_a = 27'($urandom);
        rgb_b = 27'($urandom);
        rgb_c = 24'($urandom);
        cen_a = 1'b1;
        cen_b = 1'b1;
        cen_c = 1'b1;
        idx_a = 8'd4;
        idx_b = 8'd8;
        idx_c = 8'd3;
        test_reset();
        test_default_timing();
        test_cells_random();
        test_border_cursor();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/grid_video_gen.md
Name: grid_video_gen

Overview:
- Parametrised successor to the fixed 640x480, 3x3-panel pixel generator: a single-clock raster timing generator with a COLS x ROWS cell grid.
- Each cell shows a 3-bit {r,g,b} on/off colour.
- Adds optional grid-line borders, a blinking cursor cell and configurable sync polarity/timing.
- Drives the existing TMDS encoders (red/green/blue, hsync/vsync, de) in the pixclk domain.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
SYNC_POL, 1, active level of hsync/vsync
COLS, 3, grid columns (1..16)
ROWS, 3, grid rows (1..16)
BORDER, 2, grid-line thickness in pixels; 0 disables borders
BLINK_FRAMES, 30, frames per cursor blink half-period (>=1)

Ports:
pixclk  in  1  pixel clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cell_rgb  in  3*COLS*ROWS  cell n=row*COLS+col colour at [3n+2:3n] = {r,g,b}
cursor_en  in  1  enable cursor highlight
cursor_idx  in  8  cursor cell index n; values >= COLS*ROWS mean no cursor
red  out  8  pixel red
green  out  8  pixel green
blue  out  8  pixel blue
hsync  out  1  horizontal sync, level SYNC_POL when active
vsync  out  1  vertical sync, level SYNC_POL when active
de  out  1  display enable (active area)
frame_start  out  1  one-cycle pulse aligned with first active pixel (0,0) of every frame

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Counter x wraps H_TOTAL-1 -> 0. Counter y increments on x wrap and wraps V_TOTAL-1 -> 0.
- Sync regions:
  - hsync active for H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC.
  - vsync active for V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC.
  - de = (x<H_ACTIVE)&&(y<V_ACTIVE).
- Latency: every output reflects counter position (x,y) exactly 2 cycles later. red/green/blue/hsync/vsync/de/frame_start are mutually aligned. No division in RTL.
- Cell geometry:
  - CW = H_ACTIVE/COLS, CH = V_ACTIVE/ROWS (elaboration-time constants).
  - col/row counters advance at multiples of CW/CH, held by sub-counters. The last col/row absorbs the remainder (default: col 2 spans x=426..639, 214 px; row 2 spans 320..479).
  - col, sub-counter and col-relative x reset to 0 at x==0; row likewise at y==0.
- Snapshot:
  - cell_rgb, cursor_en and cursor_idx are captured into internal registers on the cycle the counter is at (H_TOTAL-1, V_TOTAL-1).
  - The snapshot applies to the whole following frame. Input changes mid-frame have no visible effect.
- Pixel colour, active area only, priority high->low:
  1. Border: BORDER>0 and (col>0 and x-offset-in-cell < BORDER, or row>0 and y-offset-in-cell < BORDER) -> white (FF,FF,FF).
  2. Cursor: snapshot cursor_en=1, cell index == snapshot cursor_idx, blink_phase=1 -> the cell's colour bits inverted.
  3. Otherwise each channel = bit ? 8'hFF : 8'h00.
- Outside the active area, rgb = 0.
- Blink:
  - A frame counter counts frame_start pulses. blink_phase toggles when it reaches BLINK_FRAMES, and the counter clears.
  - The toggle takes effect from the next frame.
- Reset, asynchronous, any time including mid-frame:
  - x=y=0, col/row/sub-counters 0, snapshot 0, blink_phase 0, frame counter 0, pipeline cleared.
  - Outputs: rgb=0, de=0, frame_start=0, hsync=vsync=~SYNC_POL.
- After release:
  - First de and frame_start assert on the 3rd rising edge (cycle 2 relative to counter (0,0)).
  - Frame 0 shows all-black cells, with borders still drawn. Inputs sampled at the end of frame 0 appear in frame 1.
- COLS=1 or ROWS=1: no border in that dimension. BORDER >= CW or CH is illegal (elaboration assertion).

Test Plan:
- Reset, defaults: after rst_n rises, hsync low for 656 cycles, then high 96, period 800. vsync period 420000 cycles with a 1600-cycle pulse. de high 640 of 800 per line for 480 lines. frame_start once per frame, coincident with the first de.
- cell_rgb: cell0=3'b100, cell4=3'b010, others 0, held from reset; BORDER=0.
  - Frame 1, line 0: x=0..212 red=FF.
  - Line 160: x=213..425 green=FF, all else 0.
  - Frame 0 entirely black.
- Border, defaults: line 0 at x=213,214,426,427 white; line 160 all 640 pixels white; line 162 at x=215 shows the cell colour, not white.
- Cursor: BLINK_FRAMES=2, cursor_en=1, cursor_idx=8, cell8=3'b000.
  - Cell 8 white in frames where blink_phase=1, black otherwise; period 4 frames.
  - cursor_idx=9 -> never highlighted.
- Remainder/params: H_ACTIVE=20, V_ACTIVE=10, COLS=3, ROWS=3, BORDER=1, small porches.
  - Col 2 spans x=12..19 (8 px); row 2 spans y=6..9.
  - SYNC_POL=0 inverts both syncs.
- Mid-frame events:
  - Change cell_rgb at line 200: no change until the next frame.
  - Assert rst_n=0 at line 300: outputs go to reset values immediately (asynchronously), and timing restarts from (0,0) after release.
